// File: rtl/merlin_fetch_requester_pkg.sv
// Shared definitions for the fetch requester: entry layout, entry width and
// FSM state encodings.
package merlin_fetch_requester_pkg;

    localparam int C_FIFO_WIDTH    = 65;
    localparam int FETCH_RERR_BIT  = 64;
    localparam int FETCH_PC_MSB    = 63;
    localparam int FETCH_PC_LSB    = 32;
    localparam int FETCH_INSTR_MSB = 31;
    localparam int FETCH_INSTR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [C_FIFO_WIDTH-1:0] fetch_entry(
        input logic        rerr,
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        return {rerr, pc, instr};
    endfunction

endpackage

// File: rtl/merlin_fetch_requester_if.sv
// Instruction bus and fetch FIFO write-side signals. The requester is the
// master; the bus/FIFO side is the slave.
interface merlin_fetch_requester_if;
    import merlin_fetch_requester_pkg::*;

    logic                    ireqvalid_o;
    logic                    ireqready_i;
    logic [31:0]             ireqaddr_o;
    logic                    irspvalid_i;
    logic                    irsprerr_i;
    logic [31:0]             irspdata_i;
    logic                    fifo_flush_o;
    logic                    fifo_wr_o;
    logic [C_FIFO_WIDTH-1:0] fifo_din_o;
    logic                    fifo_rd_i;

    modport master (
        output ireqvalid_o, ireqaddr_o, fifo_flush_o, fifo_wr_o, fifo_din_o,
        input  ireqready_i, irspvalid_i, irsprerr_i, irspdata_i, fifo_rd_i
    );

    modport slave (
        input  ireqvalid_o, ireqaddr_o, fifo_flush_o, fifo_wr_o, fifo_din_o,
        output ireqready_i, irspvalid_i, irsprerr_i, irspdata_i, fifo_rd_i
    );

endinterface

// File: rtl/merlin_fetch_requester_tracker.sv
// Credit bookkeeping for the fetch requester: requests in flight, stale
// responses still to be discarded, and FIFO occupancy.
module merlin_fetch_tracker #(
    parameter int C_FIFO_DEPTH_X    = 1,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic accept_i,
    input  logic rsp_valid_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic pc_load_i,
    output logic credit_ok_o,
    output logic drop_o
);

    localparam int          OW       = C_FIFO_DEPTH_X + 1;
    localparam int          IW       = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam logic [31:0] DEPTH    = 32'(1 << C_FIFO_DEPTH_X);
    localparam logic [31:0] MAX_OUTS = 32'(C_MAX_OUTSTANDING);

    logic [OW-1:0] occ_q;
    logic [IW-1:0] inflight_q;
    logic [IW-1:0] drop_q;
    logic [IW-1:0] inflight_next;
    logic [31:0]   claimed;

    // Every response retires one in-flight request, whether pushed or dropped.
    assign inflight_next = inflight_q + IW'(accept_i) - IW'(rsp_valid_i);
    assign drop_o        = (drop_q != '0);

    // Entries already stored plus live requests must leave room in the FIFO.
    always_comb begin
        claimed     = 32'(occ_q) + 32'(inflight_q) - 32'(drop_q);
        credit_ok_o = (claimed < DEPTH) && (32'(inflight_q) < MAX_OUTS);
    end

    // Counter update; a redirect turns everything in flight into stale traffic.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_q      <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= inflight_next;
            if (pc_load_i) begin
                drop_q <= inflight_next;
                occ_q  <= '0;
            end else begin
                if (rsp_valid_i && drop_o)
                    drop_q <= drop_q - IW'(1);
                occ_q <= occ_q + OW'(push_i) - OW'(pop_i);
            end
        end
    end

`ifndef SYNTHESIS
    rsp_needs_inflight: assert property (@(posedge clk_i) disable iff (reset_i)
        !(rsp_valid_i && (inflight_q == '0)));
    pop_needs_entry: assert property (@(posedge clk_i) disable iff (reset_i)
        !(pop_i && (occ_q == '0)));
`endif

endmodule

// File: rtl/merlin_fetch_requester.sv
// Instruction fetch requester: issues sequential word fetches, tags in-order
// responses with their PC and pushes them into the fetch FIFO.
// Optional macro RV_FETCH_PERF_EN adds saturating drop/stall counters.
//
// state | meaning
// IDLE  | after reset, no requests until the first redirect
// RUN   | issuing requests while FIFO credit and outstanding limit allow
// HALT  | bus error seen; no new requests, in-flight responses still pushed
module merlin_fetch_requester
    import merlin_fetch_requester_pkg::*;
#(
    parameter int C_FIFO_DEPTH_X    = 1,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pc_load_i,
    input  logic [31:0] pc_i,
    merlin_fetch_requester_if.master bus
`ifdef RV_FETCH_PERF_EN
    ,
    output logic [31:0] perf_drop_o,
    output logic [31:0] perf_stall_o
`endif
);

    fetch_state_e state_q;
    logic [31:0]  req_pc_q;
    logic [31:0]  rsp_pc_q;
    logic         credit_ok;
    logic         drop;
    logic         req_valid;
    logic         accept;
    logic         push;
    logic         pc_align_unused;

    assign pc_align_unused = ^pc_i[1:0];

    assign req_valid = ~reset_i & (state_q == RUN) & ~pc_load_i & credit_ok;
    assign accept    = req_valid & bus.ireqready_i;
    assign push      = ~reset_i & bus.irspvalid_i & ~drop & ~pc_load_i;

    assign bus.ireqvalid_o  = req_valid;
    assign bus.ireqaddr_o   = req_pc_q;
    assign bus.fifo_flush_o = pc_load_i & ~reset_i;
    assign bus.fifo_wr_o    = push;
    assign bus.fifo_din_o   = fetch_entry(bus.irsprerr_i, rsp_pc_q, bus.irspdata_i);

    merlin_fetch_tracker #(
        .C_FIFO_DEPTH_X    (C_FIFO_DEPTH_X),
        .C_MAX_OUTSTANDING (C_MAX_OUTSTANDING)
    ) u_tracker (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .accept_i    (accept),
        .rsp_valid_i (bus.irspvalid_i),
        .push_i      (push),
        .pop_i       (bus.fifo_rd_i),
        .pc_load_i   (pc_load_i),
        .credit_ok_o (credit_ok),
        .drop_o      (drop)
    );

    // Sequencing FSM plus request/response PCs; a redirect always restarts fetch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            rsp_pc_q <= '0;
        end else if (pc_load_i) begin
            state_q  <= RUN;
            req_pc_q <= {pc_i[31:2], 2'b00};
            rsp_pc_q <= {pc_i[31:2], 2'b00};
        end else begin
            if (accept)
                req_pc_q <= req_pc_q + 32'd4;
            if (push)
                rsp_pc_q <= rsp_pc_q + 32'd4;
            if ((state_q == RUN) && push && bus.irsprerr_i)
                state_q <= HALT;
        end
    end

`ifdef RV_FETCH_PERF_EN
    logic [31:0] perf_drop_q;
    logic [31:0] perf_stall_q;

    // Saturating counts of discarded responses and credit-limited RUN cycles.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (bus.irspvalid_i && (drop || pc_load_i) && (perf_drop_q != '1))
                perf_drop_q <= perf_drop_q + 32'd1;
            if ((state_q == RUN) && !pc_load_i && !credit_ok && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_drop_o  = perf_drop_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_merlin_fetch_requester.sv
// Scoreboard bench for merlin_fetch_requester: directed scenarios followed by
// random traffic, checked against a request-queue model of the fetch path.
module tb_merlin_fetch_requester;

    localparam int X    = 1;
    localparam int D    = 1 << X;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_load;
    logic [31:0] pc;
`ifdef RV_FETCH_PERF_EN
    logic [31:0] perf_drop;
    logic [31:0] perf_stall;
`endif

    merlin_fetch_requester_if bus();

    merlin_fetch_requester #(
        .C_FIFO_DEPTH_X    (X),
        .C_MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .pc_load_i (pc_load),
        .pc_i      (pc),
        .bus       (bus)
`ifdef RV_FETCH_PERF_EN
        ,
        .perf_drop_o  (perf_drop),
        .perf_stall_o (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 running, 2 halted on error.
    int          mode;
    logic [31:0] m_req_pc;
    logic [31:0] live_q[$];   // addresses of requests whose responses will be kept
    int          stale;       // responses still owed to requests from before a redirect
    int          occ;
    logic [64:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic pl, input logic [31:0] pcv, input logic rdy,
                        input logic rv, input logic rerr, input logic [31:0] rdata,
                        input logic rd);
        logic        exp_valid;
        logic        exp_wr;
        logic [31:0] tag;
        int          inflight;
        @(negedge clk);
        inflight = live_q.size() + stale;
        if (inflight == 0) rv = 1'b0;
        if (occ == 0) rd = 1'b0;
        pc_load         = pl;
        pc              = pcv;
        bus.ireqready_i = rdy;
        bus.irspvalid_i = rv;
        bus.irsprerr_i  = rerr;
        bus.irspdata_i  = rdata;
        bus.fifo_rd_i   = rd;
        #1;
        exp_valid = (mode == 1) && !pl && ((occ + live_q.size()) < D) && (inflight < MAXO);
        check("ireqvalid", 65'(bus.ireqvalid_o), 65'(exp_valid));
        check("ireqaddr", 65'(bus.ireqaddr_o), 65'(m_req_pc));
        check("fifo_flush", 65'(bus.fifo_flush_o), 65'(pl));
        exp_wr = 1'b0;
        if (rv) begin
            if (stale > 0) begin
                stale--;
            end else begin
                tag = live_q.pop_front();
                if (!pl) begin
                    exp_wr = 1'b1;
                    exp_q.push_back({rerr, tag, rdata});
                    occ++;
                    if (rerr && mode == 1) mode = 2;
                end
            end
        end
        check("fifo_wr", 65'(bus.fifo_wr_o), 65'(exp_wr));
        if (rd && !pl) occ--;
        if (exp_valid && rdy) begin
            live_q.push_back(m_req_pc);
            m_req_pc = m_req_pc + 32'd4;
        end
        if (pl) begin
            stale    = stale + live_q.size();
            live_q.delete();
            occ      = 0;
            mode     = 1;
            m_req_pc = {pcv[31:2], 2'b00};
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected entry.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.fifo_wr_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL fifo_din: got unexpected write %h, expected no write", bus.fifo_din_o);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_din", bus.fifo_din_o, e);
                end
            end
        end
    end

    initial begin
        logic        pl, rdy, rv, rerr, rd;
        logic [31:0] pcv;
        mode     = 0;
        m_req_pc = '0;
        stale    = 0;
        occ      = 0;
        reset           = 1'b1;
        pc_load         = 1'b0;
        pc              = '0;
        bus.ireqready_i = 1'b0;
        bus.irspvalid_i = 1'b0;
        bus.irsprerr_i  = 1'b0;
        bus.irspdata_i  = '0;
        bus.fifo_rd_i   = 1'b0;

        repeat (2) @(negedge clk);
        pc_load         = 1'b1;
        pc              = 32'h0000_0100;
        bus.ireqready_i = 1'b1;
        bus.irspvalid_i = 1'b1;
        #1;
        check("reset_flush", 65'(bus.fifo_flush_o), 65'(0));
        check("reset_ireqvalid", 65'(bus.ireqvalid_o), 65'(0));
        check("reset_fifo_wr", 65'(bus.fifo_wr_o), 65'(0));
        check("reset_ireqaddr", 65'(bus.ireqaddr_o), 65'(0));
        @(negedge clk);
        pc_load         = 1'b0;
        bus.ireqready_i = 1'b0;
        bus.irspvalid_i = 1'b0;
        reset           = 1'b0;

        // Fill the two credits, then responses without pops.
        step(1, 32'h100, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 32'hAAAA_0001, 0);
        step(0, 0, 1, 1, 0, 32'hAAAA_0002, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        // Redirect with two stale requests outstanding.
        step(1, 32'h2003, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h1111_1111, 0);
        step(0, 0, 0, 1, 0, 32'h2222_2222, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'hBBBB_0000, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        // Redirect coinciding with an arriving response, then a bus error.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 32'h300, 1, 1, 0, 32'hCCCC_0000, 0);
        step(0, 0, 0, 1, 0, 32'hCCCC_0001, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0);
        step(0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        // Address wrap at the top of memory.
        step(1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h1234_5678, 0);
        step(0, 0, 0, 1, 0, 32'h9ABC_DEF0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            pl   = ($urandom_range(0, 15) == 0);
            pcv  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rdy  = ($urandom_range(0, 3) != 0);
            rv   = ($urandom_range(0, 2) != 0);
            rerr = ($urandom_range(0, 15) == 0);
            rd   = ($urandom_range(0, 2) == 0);
            step(pl, pcv, rdy, rv, rerr, $urandom, rd);
        end

        for (int i = 0; i < MAXO + 2; i++)
            step(0, 0, 0, 1, 0, $urandom, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        check("scoreboard_empty", 65'(exp_q.size()), 65'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
